// File: rtl/muldiv_pkg.sv
// Shared definitions for the multi-cycle multiply/divide/modulo unit.
// Contents: operation encodings, FSM state encoding, the quotient value
// returned on divide-by-zero, and a helper that classifies an opcode.
package muldiv_pkg;

   typedef enum logic [1:0] {
      OP_MUL = 2'd0,
      OP_DIV = 2'd1,
      OP_MOD = 2'd2,
      OP_RSV = 2'd3   // reserved, executed as MUL
   } op_e;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RUN    = 2'd1,
      FINISH = 2'd2
   } state_e;

   // Wide enough for any supported WIDTH; users slice the low WIDTH bits.
   localparam int MAX_WIDTH = 64;
   localparam logic [MAX_WIDTH-1:0] DIV0_QUOTIENT = {MAX_WIDTH{1'b1}};

   // True for the operations that run the restoring-division sequence.
   function automatic logic is_div_op(input op_e op);
      return (op == OP_DIV) || (op == OP_MOD);
   endfunction

endpackage

// File: rtl/muldiv_if.sv
// Core <-> multiply/divide unit bus.
// master (core): drives start, op, a, b; observes busy, stall, done,
//                result, div_by_zero.
// slave  (unit): the reverse.
interface muldiv_if #(
   parameter int WIDTH = 32
);
   logic             start;
   logic [1:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             busy;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;
   logic             div_by_zero;

   modport master (
      output start, op, a, b,
      input  busy, stall, done, result, div_by_zero
   );

   modport slave (
      input  start, op, a, b,
      output busy, stall, done, result, div_by_zero
   );
endinterface

// File: rtl/muldiv_datapath.sv
// Operand, accumulator and remainder registers plus the single-iteration
// step logic shared by shift-add multiply and restoring division.
// Ports:
//   clk, reset  rising-edge clock, synchronous active-high reset
//   load        capture a/b as fresh operands and clear the accumulator
//   step        perform one iteration
//   div_mode    1 = division step, 0 = multiply step
//   a, b        operands presented at load
//   quo_nxt     quotient after the current iteration
//   low_nxt     low WIDTH bits of accumulator after the current iteration
//               (product in MUL mode, remainder in DIV/MOD mode)
module muldiv_datapath #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             load,
   input  logic             step,
   input  logic             div_mode,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   output logic [WIDTH-1:0] quo_nxt,
   output logic [WIDTH-1:0] low_nxt
);
   // x: multiplicand, or dividend that turns into the quotient as it shifts.
   // y: multiplier, or divisor.
   // acc: product accumulator, or WIDTH+1 bit partial remainder.
   logic [WIDTH-1:0] x;
   logic [WIDTH-1:0] y;
   logic [WIDTH:0]   acc;
   logic [WIDTH-1:0] x_n;
   logic [WIDTH-1:0] y_n;
   logic [WIDTH:0]   acc_n;
   logic [WIDTH:0]   rem_sh;

   // Next-state values for one multiply or division iteration.
   always_comb begin
      // The remainder never reaches the divisor, so its top bit is zero and
      // truncating after the shift loses nothing.
      rem_sh = (WIDTH+1)'({acc, x[WIDTH-1]});
      x_n    = x;
      y_n    = y;
      acc_n  = acc;
      if (div_mode) begin
         if (rem_sh >= {1'b0, y}) begin
            acc_n = rem_sh - {1'b0, y};
            x_n   = {x[WIDTH-2:0], 1'b1};
         end else begin
            acc_n = rem_sh;
            x_n   = {x[WIDTH-2:0], 1'b0};
         end
      end else begin
         if (y[0]) begin
            acc_n = {1'b0, acc[WIDTH-1:0] + x};
         end else begin
            acc_n = {1'b0, acc[WIDTH-1:0]};
         end
         x_n = {x[WIDTH-2:0], 1'b0};
         y_n = {1'b0, y[WIDTH-1:1]};
      end
   end

   assign quo_nxt = x_n;
   assign low_nxt = acc_n[WIDTH-1:0];

   // Operand and accumulator registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         x   <= {WIDTH{1'b0}};
         y   <= {WIDTH{1'b0}};
         acc <= {(WIDTH+1){1'b0}};
      end else if (load) begin
         x   <= a;
         y   <= b;
         acc <= {(WIDTH+1){1'b0}};
      end else if (step) begin
         x   <= x_n;
         y   <= y_n;
         acc <= acc_n;
      end else begin
         x   <= x;
         y   <= y;
         acc <= acc;
      end
   end

endmodule

// File: rtl/muldiv_sequencer.sv
// Multi-cycle unsigned multiply / divide / modulo unit.
// A start pulse in IDLE latches the operands; the unit then runs WIDTH
// shift-add or restoring-division iterations while holding stall high, and
// pulses done for one cycle with the registered result.
// Ports:
//   clk    rising-edge clock
//   reset  synchronous active-high reset
//   bus    muldiv_if.slave: start/op/a/b in; busy/stall/done/result/
//          div_by_zero out
// Build option: define MULDIV_EARLY_OUT_EN to skip the iterations for
// MUL with a zero operand and for DIV/MOD with a < b.
module muldiv_sequencer
   import muldiv_pkg::*;
#(
   parameter int WIDTH = 32
) (
   input  logic    clk,
   input  logic    reset,
   muldiv_if.slave bus
);
   localparam int CW = $clog2(WIDTH + 1);

   state_e           state;
   logic [CW-1:0]    count;
   op_e              op_q;
   logic             done_q;
   logic [WIDTH-1:0] result_q;
   logic             dbz_q;

   op_e              in_op;
   logic             in_div;
   logic             in_b_zero;
   logic             early_out;
   logic [WIDTH-1:0] early_result;
   logic             load;
   logic             step;
   logic             div_mode;
   logic [WIDTH-1:0] quo_nxt;
   logic [WIDTH-1:0] low_nxt;

   assign in_op     = op_e'(bus.op);
   assign in_div    = is_div_op(in_op);
   assign in_b_zero = (bus.b == {WIDTH{1'b0}});
   assign load      = (state == IDLE) && bus.start;
   assign step      = (state == RUN);
   assign div_mode  = is_div_op(op_q);

   // Trivial operations that need no iterations.
   always_comb begin
      early_out    = 1'b0;
      early_result = {WIDTH{1'b0}};
`ifdef MULDIV_EARLY_OUT_EN
      if (!in_div && ((bus.a == {WIDTH{1'b0}}) || in_b_zero)) begin
         early_out    = 1'b1;
         early_result = {WIDTH{1'b0}};
      end else if (in_div && (bus.a < bus.b)) begin
         early_out    = 1'b1;
         early_result = (in_op == OP_MOD) ? bus.a : {WIDTH{1'b0}};
      end else begin
         early_out    = 1'b0;
         early_result = {WIDTH{1'b0}};
      end
`else
      early_out    = 1'b0;
      early_result = {WIDTH{1'b0}};
`endif
   end

   muldiv_datapath #(.WIDTH(WIDTH)) u_datapath (
      .clk      (clk),
      .reset    (reset),
      .load     (load),
      .step     (step),
      .div_mode (div_mode),
      .a        (bus.a),
      .b        (bus.b),
      .quo_nxt  (quo_nxt),
      .low_nxt  (low_nxt)
   );

   // Control FSM with registered done/result/div_by_zero.
   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= IDLE;
         count    <= {CW{1'b0}};
         op_q     <= OP_MUL;
         done_q   <= 1'b0;
         result_q <= {WIDTH{1'b0}};
         dbz_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state)
            IDLE: begin
               if (bus.start) begin
                  op_q  <= in_op;
                  count <= CW'(WIDTH);
                  dbz_q <= 1'b0;
                  if (in_div && in_b_zero) begin
                     // Divide by zero: quotient all ones, remainder = dividend.
                     state    <= FINISH;
                     done_q   <= 1'b1;
                     dbz_q    <= 1'b1;
                     result_q <= (in_op == OP_MOD) ? bus.a
                                                   : DIV0_QUOTIENT[WIDTH-1:0];
                  end else if (early_out) begin
                     state    <= FINISH;
                     done_q   <= 1'b1;
                     result_q <= early_result;
                  end else begin
                     state <= RUN;
                  end
               end else begin
                  state <= IDLE;
               end
            end
            RUN: begin
               count <= count - CW'(1);
               if (count == CW'(1)) begin
                  // Capture the outcome of the final iteration directly.
                  state    <= FINISH;
                  done_q   <= 1'b1;
                  result_q <= (op_q == OP_DIV) ? quo_nxt : low_nxt;
               end else begin
                  state <= RUN;
               end
            end
            FINISH: begin
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   assign bus.busy        = (state != IDLE);
   // Low in FINISH so the core retires and writes back that cycle.
   assign bus.stall       = ((state == IDLE) && bus.start) || (state == RUN);
   assign bus.done        = done_q;
   assign bus.result      = result_q;
   assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Scoreboard bench for muldiv_sequencer: the driver pushes the expected
// result, div_by_zero flag and done cycle for each operation; a monitor pops
// and compares whenever done is seen.
module tb_muldiv_sequencer;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   muldiv_if #(.WIDTH(32)) bus ();

   muldiv_sequencer #(.WIDTH(32)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

`ifdef MULDIV_EARLY_OUT_EN
   localparam int EARLY_LAT = 1;
`else
   localparam int EARLY_LAT = 33;
`endif
   localparam int FULL_LAT = 33;

   typedef struct {
      logic [31:0] res;
      logic        dbz;
      int          exp_cyc;
      int          id;
   } exp_t;

   exp_t sb[$];
   int   cyc    = 0;
   int   n_vec  = 0;
   int   n_fail = 0;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
      end
   endtask

   // Monitor: compare every done pulse against the oldest expectation.
   always @(negedge clk) begin : monitor
      exp_t e;
      if (bus.done === 1'b1) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_fail++;
            $display("FAIL spurious_done: actual done=1 at cycle %0d required no done", cyc);
         end else begin
            e = sb.pop_front();
            chk($sformatf("result#%0d", e.id), bus.result, e.res);
            chk($sformatf("div_by_zero#%0d", e.id), {31'd0, bus.div_by_zero}, {31'd0, e.dbz});
            chk($sformatf("done_cycle#%0d", e.id), 32'(cyc), 32'(e.exp_cyc));
         end
      end
   end

   task automatic run_op(input int id, input logic [1:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_res,
                         input logic exp_dbz, input int lat, input bit poke);
      int   stall_cnt = 0;
      bit   finished  = 1'b0;
      exp_t e;
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = op;
      bus.a     = a;
      bus.b     = b;
      #1;
      chk($sformatf("stall_on_start#%0d", id), {31'd0, bus.stall}, 32'd1);
      e.res     = exp_res;
      e.dbz     = exp_dbz;
      e.exp_cyc = cyc + lat;
      e.id      = id;
      sb.push_back(e);
      for (int k = 0; k < 100 && !finished; k++) begin
         @(negedge clk);
         // Operands change after acceptance; optional extra start while busy.
         bus.start = (poke && k == 4);
         bus.op    = 2'($urandom);
         bus.a     = $urandom;
         bus.b     = $urandom;
         #1;
         if (bus.stall) stall_cnt++;
         if (sb.size() == 0) finished = 1'b1;
      end
      bus.start = 1'b0;
      if (!finished) begin
         n_vec++;
         n_fail++;
         $display("FAIL timeout#%0d: actual no done within 100 cycles required done", id);
         sb.delete();
      end
      chk($sformatf("stall_cycles#%0d", id), 32'(stall_cnt), 32'(lat - 1));
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: actual simulation still running required completion");
      $fatal(1);
   end

   initial begin
      int c;
      reset     = 1'b1;
      bus.start = 1'b0;
      bus.op    = 2'd0;
      bus.a     = 32'd0;
      bus.b     = 32'd0;
      repeat (3) @(negedge clk);
      #1;
      chk("reset_busy",   {31'd0, bus.busy},        32'd0);
      chk("reset_stall",  {31'd0, bus.stall},       32'd0);
      chk("reset_done",   {31'd0, bus.done},        32'd0);
      chk("reset_result", bus.result,               32'd0);
      chk("reset_dbz",    {31'd0, bus.div_by_zero}, 32'd0);
      reset = 1'b0;

      run_op( 1, 2'd0, 32'd7,          32'd6,        32'd42,         1'b0, FULL_LAT, 1'b0);
      run_op( 2, 2'd1, 32'd100,        32'd7,        32'd14,         1'b0, FULL_LAT, 1'b0);
      run_op( 3, 2'd2, 32'd100,        32'd7,        32'd2,          1'b0, FULL_LAT, 1'b0);
      run_op( 4, 2'd1, 32'd5,          32'd0,        32'hFFFF_FFFF,  1'b1, 1,        1'b0);
      run_op( 5, 2'd2, 32'd5,          32'd0,        32'd5,          1'b1, 1,        1'b0);
      run_op( 6, 2'd1, 32'd1000,       32'd10,       32'd100,        1'b0, FULL_LAT, 1'b0);
      run_op( 7, 2'd0, 32'hFFFF_FFFF,  32'd2,        32'hFFFF_FFFE,  1'b0, FULL_LAT, 1'b1);
      run_op( 8, 2'd3, 32'd5,          32'd4,        32'd20,         1'b0, FULL_LAT, 1'b0);
      run_op( 9, 2'd0, 32'h0001_0000,  32'h0001_0000, 32'd0,         1'b0, FULL_LAT, 1'b0);
      run_op(10, 2'd1, 32'hFFFF_FFFF,  32'd1,        32'hFFFF_FFFF,  1'b0, FULL_LAT, 1'b0);
      run_op(11, 2'd2, 32'hFFFF_FFFF,  32'h10,       32'hF,          1'b0, FULL_LAT, 1'b0);
      run_op(12, 2'd1, 32'd3,          32'd9,        32'd0,          1'b0, EARLY_LAT, 1'b0);
      run_op(13, 2'd2, 32'd3,          32'd9,        32'd3,          1'b0, EARLY_LAT, 1'b0);
      run_op(14, 2'd0, 32'd0,          32'd123,      32'd0,          1'b0, EARLY_LAT, 1'b0);
      run_op(15, 2'd0, 32'd123,        32'd0,        32'd0,          1'b0, EARLY_LAT, 1'b0);
      run_op(16, 2'd1, 32'd7,          32'd7,        32'd1,          1'b0, FULL_LAT, 1'b0);

      // Reset ten cycles into a MUL: aborts with no done and clears result.
      @(negedge clk);
      bus.start = 1'b1;
      bus.op    = 2'd0;
      bus.a     = 32'd3;
      bus.b     = 32'd3;
      c = cyc;
      @(negedge clk);
      bus.start = 1'b0;
      while (cyc < c + 10) @(negedge clk);
      #1;
      chk("busy_before_abort", {31'd0, bus.busy}, 32'd1);
      reset = 1'b1;
      @(negedge clk);
      #1;
      chk("abort_busy",   {31'd0, bus.busy},        32'd0);
      chk("abort_stall",  {31'd0, bus.stall},       32'd0);
      chk("abort_result", bus.result,               32'd0);
      chk("abort_done",   {31'd0, bus.done},        32'd0);
      reset = 1'b0;
      repeat (40) @(negedge clk);
      run_op(17, 2'd0, 32'd3, 32'd3, 32'd9, 1'b0, FULL_LAT, 1'b0);

      // Start and reset together: reset wins, nothing is accepted.
      @(negedge clk);
      reset     = 1'b1;
      bus.start = 1'b1;
      bus.op    = 2'd0;
      bus.a     = 32'd2;
      bus.b     = 32'd2;
      @(negedge clk);
      #1;
      chk("reset_wins_busy",   {31'd0, bus.busy}, 32'd0);
      chk("reset_wins_result", bus.result,        32'd0);
      reset     = 1'b0;
      bus.start = 1'b0;
      repeat (40) @(negedge clk);

      chk("scoreboard_empty", 32'(sb.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

endmodule
